// File: rtl/iwrr_weight_counter.sv
// iwrr_weight_counter: per-requester credit store for the IWRR arbiter.
// Holds the remaining weight of each requester for the current round.
// Decrements the granted requester's credit on every legal grant.
// Reloads all credits from the configured weights when the downstream
// round-completion detector flags the last grant of a round.
module iwrr_weight_counter #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1]    cfg_weight_i,
    input  logic [P_REQUESTER_NUM-1:0]               grant_i,
    input  logic                                     round_comp_i,
    input  logic                                     flush_i,
    output logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1]    req_weight_o,
    output logic [P_REQUESTER_NUM-1:0]               req_weight_remain_o,
    output logic [P_WEIGHT_W-1:0]                    num_grant_req_o,
    output logic                                     round_active_o,
    output logic                                     round_done_o,
    output logic                                     grant_err_o
);

    localparam int N       = P_REQUESTER_NUM;
    localparam int W       = P_WEIGHT_W;
    localparam int NW      = N * W;
    localparam int MAX_CNT = (1 << W) - 1;

    localparam logic [W-1:0] ONE_W = W'(1);

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [0:NW-1] credit_q, credit_d;
    logic          round_done_q, round_done_d;
    logic          grant_err_q, grant_err_d;

    logic          cfg_any;
    logic          credit_any;
    logic          grant_hits_credit;
    logic          grant_legal;
    int            active_cnt;

    // Outputs derived from registered state only, so nothing loops back through the detector
    always_comb begin
        active_cnt          = 0;
        req_weight_remain_o = '0;
        for (int k = 0; k < N; k++) begin
            if (credit_q[k*W +: W] > ONE_W) begin
                req_weight_remain_o[k] = 1'b1;
            end
            if (credit_q[k*W +: W] != '0) begin
                active_cnt = active_cnt + 1;
            end
        end
        num_grant_req_o = (active_cnt > MAX_CNT) ? W'(MAX_CNT) : W'(active_cnt);
        req_weight_o    = credit_q;
        round_active_o  = (state_q == ST_RUN);
        round_done_o    = round_done_q;
        grant_err_o     = grant_err_q;
    end

    // Classify the incoming grant: legal only if one-hot and aimed at a nonzero credit
    always_comb begin
        grant_hits_credit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant_i[k] && (credit_q[k*W +: W] != '0)) begin
                grant_hits_credit = 1'b1;
            end
        end
        grant_legal = $onehot(grant_i) && grant_hits_credit;
        cfg_any     = |cfg_weight_i;
        credit_any  = |credit_q;
    end

    // Next-state logic: flush wins, LOAD copies the config, RUN consumes credits
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        round_done_d = 1'b0;
        grant_err_d  = 1'b0;
        if (flush_i) begin
            state_d = ST_LOAD;
        end else if (state_q == ST_LOAD) begin
            credit_d    = cfg_weight_i;
            state_d     = cfg_any ? ST_RUN : ST_LOAD;
            grant_err_d = |grant_i;
        end else begin
            if (!credit_any) begin
                state_d = ST_LOAD;
            end
            if (grant_legal) begin
                if (round_comp_i) begin
                    credit_d     = cfg_weight_i;
                    round_done_d = 1'b1;
                    state_d      = cfg_any ? ST_RUN : ST_LOAD;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (grant_i[k]) begin
                            credit_d[k*W +: W] = credit_q[k*W +: W] - ONE_W;
                        end
                    end
                end
            end else if (grant_i != '0) begin
                grant_err_d = 1'b1;
            end
        end
    end

    // State and credit registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            credit_q     <= '0;
            round_done_q <= 1'b0;
            grant_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            round_done_q <= round_done_d;
            grant_err_q  <= grant_err_d;
        end
    end

endmodule
